uart_rx: RTL and testbench

- UART serial receiver: deserializes an asynchronous 8N1 line into parallel bytes.
- Sits directly upstream of the UART-to-FIFO buffer stage and feeds it: `data_out` is that stage's byte, and `rx_done` is its "byte received" strobe.
- Downstream latches `data_out` on `rx_done`.
- `data_out` holds its value until the next good frame.

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx.sv | 120 ++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding, 8N1 line levels and the
// baud divisor helper used by both the receiver and the future transmitter.
package UartPkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    // Clock cycles per bit; integer division, the fractional part is dropped.
    function automatic int baud_div(input int clk_freq_hz, input int baud_rate);
        return clk_freq_hz / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to
// the idle level so that leaving reset never looks like a start bit.
module uart_rx_sync
    import UartPkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops
    // sample the pre-edge values and the chain really is two stages deep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= IDLE_LEVEL;
            q    <= IDLE_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification at half a bit, mid-bit data
// sampling, stop-bit check producing either rx_done or frame_err.
module uart_rx
    import UartPkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int N  = baud_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int H  = N / 2;
    localparam int CW = $clog2(N);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(N - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    generate
        if (N < 4) begin : g_bad_divisor
            $error("uart_rx: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
        end
        if (DATA_BITS < 2) begin : g_bad_width
            $error("uart_rx: DATA_BITS must be at least 2");
        end
    endgenerate

    rx_state_t            state;
    rx_state_t            state_next;
    logic                 rx_s;
    logic [CW-1:0]        clk_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] sh;
    logic                 cnt_half;
    logic                 cnt_full;
    logic                 done_next;
    logic                 err_next;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign cnt_half = (clk_cnt == CNT_HALF);
    assign cnt_full = (clk_cnt == CNT_FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rx_s == START_LEVEL) state_next = START;
            START:   if (cnt_half) state_next = (rx_s == START_LEVEL) ? DATA : IDLE;
            DATA:    if (cnt_full && bit_idx == LAST_BIT) state_next = STOP;
            STOP:    if (cnt_full) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done_next = (state == STOP) && cnt_full && (rx_s == STOP_LEVEL);
        err_next  = (state == STOP) && cnt_full && (rx_s != STOP_LEVEL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            sh        <= '0;
            data_out  <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= done_next;
            frame_err <= err_next;
            if (done_next) data_out <= sh;

            case (state)
                IDLE: clk_cnt <= '0;
                START: begin
                    if (cnt_half) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_full) begin
                        clk_cnt <= '0;
                        sh      <= {rx_s, sh[DATA_BITS-1:1]};
                        if (bit_idx != LAST_BIT) bit_idx <= bit_idx + 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: clk_cnt <= cnt_full ? '0 : clk_cnt + 1'b1;
                default: clk_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at N = 16, H = 8: table-driven frames plus
// hand-written glitch, mid-frame reset and line-break sequences, all checked
// through a pulse scoreboard that carries the expected byte and cycle.
module tb_uart_rx;

    localparam int N = 16;
    localparam int H = 8;
    // Cycles from driving the start edge (at a negedge) to the negedge on
    // which the result pulse is visible: 2 sync stages + H + 9*N + 1.
    localparam int PULSE_LAT = 155;
    // A held-low line restarts a frame every 152 + 1 cycles.
    localparam int BREAK_PERIOD = 153;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] data_out;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    uart_rx #(
        .CLK_FREQ_HZ (1_600_000),
        .BAUD_RATE   (100_000),
        .DATA_BITS   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data_out  (data_out),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        bit         exp_err;
        logic [7:0] exp_out;
    } vec_t;

    exp_t sb[$];
    int   done_cycs[$];
    exp_t mon_e;
    vec_t vecs[5];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input bit is_err, input logic [7:0] d, input int at);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        e.cyc    = at;
        sb.push_back(e);
    endtask

    // Caller is positioned on a negedge; returns on a negedge 10*N later.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (N) @(negedge clk);
        end
        rx = stop_bit;
        repeat (N) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    logic prev_pulse = 1'b0;
    logic prev_busy  = 1'b0;

    always @(negedge clk) begin
        if (!reset && (rx_done || frame_err)) begin
            check_eq("pulse_exclusive", 32'((rx_done && frame_err) || prev_pulse), 32'd0);
            check_eq("busy_falls_with_pulse", {30'd0, prev_busy, busy}, 32'b10);
            check_eq("pulse_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check_eq("pulse_kind", {30'd0, rx_done, frame_err}, mon_e.is_err ? 32'b01 : 32'b10);
                check_eq("pulse_data_out", 32'(data_out), 32'(mon_e.data));
                check_eq("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
            if (rx_done) done_cycs.push_back(cyc);
        end
        prev_pulse = rx_done || frame_err;
        prev_busy  = busy;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_n;
        int c0;

        vecs[0] = '{8'hA5, 1'b1, 40, 1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 40, 1'b1, 8'hA5};
        vecs[2] = '{8'h00, 1'b1, 0,  1'b0, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 0,  1'b0, 8'hFF};
        vecs[4] = '{8'h81, 1'b1, 200, 1'b0, 8'h81};

        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_data_out", 32'(data_out), 32'd0);
        check_eq("reset_rx_done", 32'(rx_done), 32'd0);
        check_eq("reset_frame_err", 32'(frame_err), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        idle(10);

        // Good byte, framing error, then three back-to-back frames.
        for (int i = 0; i < 5; i++) begin
            expect_pulse(vecs[i].exp_err, vecs[i].exp_out, cyc + PULSE_LAT);
            send_frame(vecs[i].data, vecs[i].stop);
            idle(vecs[i].gap);
        end
        check_eq("done_count_table", 32'(done_cycs.size()), 32'd4);
        if (done_cycs.size() == 4) begin
            check_eq("b2b_spacing_1", 32'(done_cycs[2] - done_cycs[1]), 32'd160);
            check_eq("b2b_spacing_2", 32'(done_cycs[3] - done_cycs[2]), 32'd160);
        end

        // Start glitch: 4 low cycles, rejected at the half-bit check.
        busy_n = 0;
        rx = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 4) rx = 1'b1;
            @(negedge clk);
            busy_n += int'(busy);
        end
        check_eq("glitch_busy_cycles", 32'(busy_n), 32'(H));
        check_eq("glitch_data_out", 32'(data_out), 32'h81);

        // Reset after three data bits have been sampled.
        idle(20);
        rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = (i != 2);
            repeat (N) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check_eq("busy_before_abort", 32'(busy), 32'd1);
        reset = 1'b1;
        rx    = 1'b1;
        #1;
        check_eq("abort_data_out", 32'(data_out), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_rx_done", 32'(rx_done), 32'd0);
        check_eq("abort_frame_err", 32'(frame_err), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(20);
        expect_pulse(1'b0, 8'h5A, cyc + PULSE_LAT);
        send_frame(8'h5A, 1'b1);
        idle(40);
        check_eq("done_count_after_abort", 32'(done_cycs.size()), 32'd5);

        // Line held low for about 29 bit times, released inside a START
        // window so the tail of the break is rejected as a glitch.
        c0 = cyc;
        for (int k = 0; k < 3; k++)
            expect_pulse(1'b1, 8'h5A, c0 + PULSE_LAT + k * BREAK_PERIOD);
        rx = 1'b0;
        repeat (464) @(negedge clk);
        idle(200);
        check_eq("no_done_in_break", 32'(done_cycs.size()), 32'd5);
        check_eq("break_data_out", 32'(data_out), 32'h5A);

        expect_pulse(1'b0, 8'h11, cyc + PULSE_LAT);
        send_frame(8'h11, 1'b1);
        idle(300);
        check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
        check_eq("final_data_out", 32'(data_out), 32'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
